// File: rtl/lfsr_msg_encrypter_pkg.sv
// Shared encrypt/decrypt definitions: FSM states, memory layout and LFSR helpers.
package crypt_pkg;

    localparam int unsigned MSG_LEN  = 64;
    localparam int unsigned CT_BASE  = 64;
    localparam int unsigned CFG_BASE = 61;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        RD,
        WR,
        DONE
    } state_t;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [6:0] lfsr_next(input logic [6:0] state, input logic [6:0] ptrn);
        return {state[5:0], ^(state & ptrn)};
    endfunction

    function automatic logic parity7(input logic [6:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_msg_encrypter_if.sv
// Start/Ack handshake plus data-memory port of the encrypt engine.
interface lfsr_msg_encrypter_if (input logic Clk);

    logic       Start;
    logic       Ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    modport master (
        input  Clk, Start, mem_rd_data,
        output Ack, mem_addr, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  Clk, Ack, mem_addr, mem_wr_en, mem_wr_data,
        output Start, mem_rd_data
    );

endinterface

// File: rtl/lfsr_msg_encrypter_lfsr7.sv
// 7-bit Fibonacci LFSR with synchronous load and step enable; load wins over step.
module lfsr7
    import crypt_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       step,
    input  logic [6:0] ptrn,
    output logic [6:0] state
);

    logic [6:0] r_state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= '0;
        end else if (load) begin
            r_state <= load_val;
        end else if (step) begin
            r_state <= lfsr_next(r_state, ptrn);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/lfsr_msg_encrypter.sv
// Program-1 encrypt engine: reads config and plaintext from DM, writes 64
// parity-tagged LFSR-scrambled bytes to the ciphertext region.
module lfsr_msg_encrypter
    import crypt_pkg::*;
#(
    parameter int unsigned MSG_LEN  = crypt_pkg::MSG_LEN,
    parameter int unsigned CT_BASE  = crypt_pkg::CT_BASE,
    parameter int unsigned CFG_BASE = crypt_pkg::CFG_BASE
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    localparam logic [5:0] LAST_IDX = 6'(MSG_LEN - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_start_d;
    logic [1:0] r_cfg_cnt;
    logic [5:0] r_idx;
    logic [3:0] r_pre;
    logic [6:0] r_ptrn;

    logic [6:0] w_lfsr;
    logic       w_lfsr_load;
    logic [6:0] w_lfsr_init;
    logic       w_have_src;
    logic [5:0] w_src_idx;
    logic [6:0] w_plain;
    logic [6:0] w_ct7;
    logic       w_unused;

    assign w_unused = mem_rd_data[7];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_d <= Start;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!Start && r_start_d) w_next = CFG;
            CFG:     if (r_cfg_cnt == 2'd3) w_next = RD;
            RD:      w_next = WR;
            WR:      w_next = (r_idx == LAST_IDX) ? DONE : RD;
            DONE:    if (Start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Config reads are pipelined: the byte for address 61+k arrives in CFG step k+1.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cfg_cnt <= '0;
            r_idx     <= '0;
            r_pre     <= '0;
            r_ptrn    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cfg_cnt <= '0;
                    r_idx     <= '0;
                end
                CFG: begin
                    r_cfg_cnt <= r_cfg_cnt + 2'd1;
                    if (r_cfg_cnt == 2'd1) r_pre  <= mem_rd_data[3:0];
                    if (r_cfg_cnt == 2'd2) r_ptrn <= mem_rd_data[6:0];
                end
                WR:      r_idx <= r_idx + 6'd1;
                default: ;
            endcase
        end
    end

    assign w_lfsr_load = (r_state == CFG) && (r_cfg_cnt == 2'd3);
    assign w_lfsr_init = (mem_rd_data[6:0] == 7'd0) ? 7'h01 : mem_rd_data[6:0];

    lfsr7 u_lfsr (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (w_lfsr_load),
        .load_val (w_lfsr_init),
        .step     (r_state == WR),
        .ptrn     (r_ptrn),
        .state    (w_lfsr)
    );

    // Leading pre positions are padding spaces, i.e. plaintext 0 after the -0x20 offset.
    assign w_have_src = (r_idx >= {2'b00, r_pre});
    assign w_src_idx  = r_idx - {2'b00, r_pre};
    assign w_plain    = w_have_src ? (mem_rd_data[6:0] - 7'h20) : 7'h00;
    assign w_ct7      = w_plain ^ w_lfsr;

    always_comb begin
        Ack         = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (r_state)
            CFG: begin
                if (r_cfg_cnt != 2'd3) mem_addr = 8'(CFG_BASE) + {6'b0, r_cfg_cnt};
            end
            RD: begin
                if (w_have_src) mem_addr = {2'b00, w_src_idx};
            end
            WR: begin
                mem_addr    = 8'(CT_BASE) + {2'b00, r_idx};
                mem_wr_en   = 1'b1;
                mem_wr_data = {parity7(w_ct7), w_ct7};
            end
            DONE:    Ack = 1'b1;
            default: ;
        endcase
    end

endmodule
